// File: rtl/stream_bundle_feeder_if.sv
// Stream bundle shared by the feeder and its consumers: payload, handshake,
// transfer counter and sticky overflow flag travel together.
interface StreamIf #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             ready;

  modport Src (output valid, output data, output count, output ovf, input ready);
  modport Snk (input valid, input data, input count, input ovf, output ready);
endinterface

// File: rtl/stream_bundle_feeder.sv
// Valid/ready to StreamIf producer: small FIFO with registered first-word
// fall-through head, transfer counter and sticky overflow-attempt flag.
module stream_bundle_feeder #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     flush,
  StreamIf.Src                     out,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] EMPTY  = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] FULL   = 2'd2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [1:0]       r_state;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wr_next;
  logic [PW-1:0]    w_rd_next;
  logic [PW-1:0]    w_level_next;
  logic [WIDTH-1:0] w_head_next;
  logic [1:0]       w_state_next;

  assign in_ready = (r_state != FULL);
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = r_valid && out.ready;

  assign w_wr_next    = r_wr_ptr + PW'(w_push);
  assign w_rd_next    = r_rd_ptr + PW'(w_pop);
  assign w_level_next = w_wr_next - w_rd_next;

  // The word being written this edge becomes the head only when it lands in
  // the slot the read pointer moves to, i.e. the FIFO drains to just this word.
  assign w_head_next = (w_push && (r_wr_ptr[AW-1:0] == w_rd_next[AW-1:0]))
                       ? in_data : r_mem[w_rd_next[AW-1:0]];

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = ACTIVE;
    if (w_level_next == '0)               w_state_next = EMPTY;
    else if (w_level_next == PW'(DEPTH))  w_state_next = FULL;
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // live, so resetting the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= in_data;
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_state  <= EMPTY;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop)                  r_count <= r_count + 1'b1;
      if (in_valid && !in_ready)  r_ovf   <= 1'b1;

      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_state  <= EMPTY;
        r_valid  <= 1'b0;
      end else begin
        r_wr_ptr <= w_wr_next;
        r_rd_ptr <= w_rd_next;
        r_state  <= w_state_next;
        r_valid  <= (w_level_next != '0);
        if (w_level_next != '0) r_data <= w_head_next;
      end
    end
  end

  assign level     = r_wr_ptr - r_rd_ptr;
  assign out.valid = r_valid;
  assign out.data  = r_data;
  assign out.count = r_count;
  assign out.ovf   = r_ovf;

endmodule

// File: tb/tb_stream_bundle_feeder.sv
// Randomized scoreboard bench for stream_bundle_feeder: a queue-based model
// predicts accepted words, occupancy, counter and overflow flag.
module tb_stream_bundle_feeder;

  localparam int WIDTH = 5;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             flush = 1'b0;
  logic [$clog2(DEPTH):0] level;

  StreamIf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_bus ();

  stream_bundle_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .out      (u_bus),
    .level    (level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the queue holds exactly the words the FIFO should own.
  logic [WIDTH-1:0] exp_q[$];
  int               m_level = 0;
  int               m_count = 0;
  logic             m_ovf   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_level = 0;
      m_count = 0;
      m_ovf   = 1'b0;
    end else begin
      automatic bit pop    = (m_level > 0) && u_bus.ready;
      automatic bit accept = in_valid && (m_level < DEPTH) && !flush;
      if (in_valid && m_level == DEPTH) m_ovf = 1'b1;
      if (pop) m_count = (m_count + 1) % 256;
      if (flush) begin
        exp_q.delete();
        m_level = 0;
      end else begin
        m_level = m_level - int'(pop) + int'(accept);
        if (accept) exp_q.push_back(in_data);
      end
    end
  end

  // Monitor: compares everything visible mid-cycle, pops on each transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid",    32'(u_bus.valid), 32'(m_level > 0));
      check("level",    32'(level), 32'(m_level));
      check("in_ready", 32'(in_ready), 32'(m_level < DEPTH));
      check("ovf",      32'(u_bus.ovf), 32'(m_ovf));
      check("count",    32'(u_bus.count), 32'(m_count));
      if (u_bus.valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(u_bus.data), 32'hFFFF_FFFF);
        end else begin
          check("data", 32'(u_bus.data), 32'(exp_q[0]));
          if (u_bus.ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
    in_valid    = v;
    in_data     = d;
    u_bus.ready = r;
    flush       = f;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    u_bus.ready = 1'b0;
    #2;
    check("rst_valid",    32'(u_bus.valid), 32'd0);
    check("rst_level",    32'(level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count",    32'(u_bus.count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single word: visible one cycle after acceptance, popped, count 1.
    cyc(1'b1, 5'h0B, 1'b1, 1'b0);
    check("t1_valid", 32'(u_bus.valid), 32'd1);
    check("t1_data",  32'(u_bus.data), 32'h0B);
    cyc(1'b0, '0, 1'b1, 1'b0);
    check("t1_empty", 32'(u_bus.valid), 32'd0);
    check("t1_count", 32'(u_bus.count), 32'd1);

    // Fill to full with output stalled, then an overflow attempt.
    for (int i = 1; i <= 5; i++) cyc(1'b1, WIDTH'(i), 1'b0, 1'b0);
    check("t2_level", 32'(level), 32'd4);
    check("t2_ovf",   32'(u_bus.ovf), 32'd1);
    drain();
    check("t2_count", 32'(u_bus.count), 32'd5);

    // Steady push+pop at level 2 across pointer wraps.
    cyc(1'b1, 5'h10, 1'b0, 1'b0);
    cyc(1'b1, 5'h11, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, WIDTH'(5'h12 + i), 1'b1, 1'b0);
    check("t3_level", 32'(level), 32'd2);
    drain();

    // Flush at level 3 with a simultaneous push.
    for (int i = 0; i < 3; i++) cyc(1'b1, WIDTH'(5'h1A + i), 1'b0, 1'b0);
    cyc(1'b1, 5'h1F, 1'b0, 1'b1);
    check("t5_level", 32'(level), 32'd0);
    check("t5_valid", 32'(u_bus.valid), 32'd0);
    check("t5_ovf",   32'(u_bus.ovf), 32'd1);

    // Long streaming run drives the counter through its wrap.
    for (int i = 0; i < 300; i++) cyc(1'b1, WIDTH'($urandom), 1'b1, 1'b0);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 3) != 0), WIDTH'($urandom), 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 40) == 0));
    drain();

    // Asynchronous reset mid-cycle with a word on the output.
    cyc(1'b1, 5'h07, 1'b0, 1'b0);
    cyc(1'b1, 5'h08, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid",    32'(u_bus.valid), 32'd0);
    check("ar_level",    32'(level), 32'd0);
    check("ar_count",    32'(u_bus.count), 32'd0);
    check("ar_ovf",      32'(u_bus.ovf), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++)
      cyc(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
